// File: rtl/axi_stream_master.sv
// Byte-assembled AXI4-Stream transmitter: a push commits a word to a register FIFO, and tvalid rises one edge after the push.
// Backpressure holds the head word stable; a push into a full FIFO with no pop is dropped (AXI_STREAM_MASTER_OVFL_EN flags it).
module axi_stream_master #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_byte_wr,
  input  logic [7:0]              i_byte,
  input  logic                    i_push,
  input  logic                    i_push_last,
  input  logic                    i_clr_ovfl,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_next;
  entry_t                mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  pop;
  logic                  push_ok;

  // The byte written in the same cycle as a push is part of the pushed word.
  generate
    if (DATA_WIDTH == 8) begin : g_byte_asm
      assign asm_next = i_byte_wr ? i_byte : asm_q;
    end else begin : g_wide_asm
      assign asm_next = i_byte_wr ? {i_byte, asm_q[DATA_WIDTH-1:8]} : asm_q;
    end
  endgenerate

  assign pop     = !o_empty && m_axis_tready;
  assign push_ok = i_push && (!o_full || pop);

  always_comb begin
    count_next = o_count;
    case ({push_ok, pop})
      2'b10:   count_next = o_count + 1'b1;
      2'b01:   count_next = o_count - 1'b1;
      default: count_next = o_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      asm_q <= '0;
    end else begin
      asm_q <= asm_next;
    end
  end

  // When full with a pop, wr_ptr equals rd_ptr; the head moves on at the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= {i_push_last, asm_next};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      o_count <= count_next;
      o_empty <= (count_next == '0);
      o_full  <= (count_next == FULL_CNT);
    end
  end

`ifdef AXI_STREAM_MASTER_OVFL_EN
  logic drop;
  assign drop = i_push && o_full && !pop;

  // Set has priority over clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovfl) begin
      o_overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovfl;
  assign unused_clr_ovfl = i_clr_ovfl;
  assign o_overflow      = 1'b0;
`endif

  assign m_axis_tvalid = !o_empty;
  assign m_axis_tdata  = mem[rd_ptr].data;
  assign m_axis_tlast  = mem[rd_ptr].last;

endmodule

// File: tb/tb_axi_stream_master.sv
// Bench for axi_stream_master: queue-based reference model compared every cycle, plus literal expectations per scenario.
module tb_axi_stream_master;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          byte_wr, push, push_last, clr_ovfl, tready;
  logic [7:0]    byte_in;
  logic          empty, full, overflow, tvalid, tlast;
  logic [2:0]    count;
  logic [DW-1:0] tdata;

  int checks = 0;
  int errors = 0;

  axi_stream_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_byte_wr    (byte_wr),
    .i_byte       (byte_in),
    .i_push       (push),
    .i_push_last  (push_last),
    .i_clr_ovfl   (clr_ovfl),
    .o_empty      (empty),
    .o_full       (full),
    .o_count      (count),
    .o_overflow   (overflow),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .m_axis_tdata (tdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue of {last,data}, assembly as the latest NB bytes.
  logic [DW:0]   mq[$];
  logic [7:0]    abytes[$];
  logic [DW:0]   dut_sink[$];
  bit            m_ovf;
  bit            m_pop, m_full;
  logic [DW:0]   m_word;

  function automatic logic [DW-1:0] asm_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < NB; i++) begin
      int idx = abytes.size() - 1 - i;
      if (idx >= 0) w[DW-1-8*i -: 8] = abytes[idx];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      abytes.delete();
      m_ovf = 1'b0;
    end else begin
      m_pop  = (mq.size() != 0) && tready;
      m_full = (mq.size() == DEPTH);
      if (byte_wr) begin
        abytes.push_back(byte_in);
        if (abytes.size() > NB) void'(abytes.pop_front());
      end
      m_word = {push_last, asm_word()};
      if (m_pop) void'(mq.pop_front());
      if (push && (!m_full || m_pop)) mq.push_back(m_word);
`ifdef AXI_STREAM_MASTER_OVFL_EN
      if (push && m_full && !m_pop) m_ovf = 1'b1;
      else if (clr_ovfl) m_ovf = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("tvalid", 32'(tvalid), 32'(mq.size() != 0));
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
        check("tdata", 32'(tdata), 32'(mq[0][DW-1:0]));
        check("tlast", 32'(tlast), 32'(mq[0][DW]));
      end
      if (tvalid && tready) dut_sink.push_back({tlast, tdata});
    end
  end

  task automatic drive(input logic bw, input logic [7:0] b, input logic p,
                       input logic pl, input logic clr);
    byte_wr = bw; byte_in = b; push = p; push_last = pl; clr_ovfl = clr;
    @(posedge clk); #1;
    byte_wr = 1'b0; push = 1'b0; push_last = 1'b0; clr_ovfl = 1'b0;
  endtask

  logic [15:0] exp4 [5];
  logic        ovf_exp;

  initial begin
    rst_n = 1'b0; byte_wr = 1'b0; byte_in = 8'h00; push = 1'b0;
    push_last = 1'b0; clr_ovfl = 1'b0; tready = 1'b0;
`ifdef AXI_STREAM_MASTER_OVFL_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ten squares streamed with tready held high.
    tready = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      drive(1'b1, 8'(k * k), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h00, 1'b1, 1'b0 + (k == 0), 1'b0);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sq_n", dut_sink.size(), 10);
    for (int k = 9; k >= 0; k--) begin
      if (dut_sink.size() > 9 - k) begin
        check("sq_data", 32'(dut_sink[9-k][DW-1:0]), 32'(k * k));
        check("sq_last", 32'(dut_sink[9-k][DW]), 32'(k == 0));
      end
    end
    dut_sink.delete();

    // Fill with tready low.
    tready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      drive(1'b1, 8'(v * 8'h11), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'(v * 8'h11), 1'b1, 1'b0, 1'b0);
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    check("fill_tdata", 32'(tdata), 32'h1111);

    // Push into full FIFO without a pop is dropped.
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'(ovf_exp));
    check("ovf_count", 32'(count), 4);
    check("ovf_tdata", 32'(tdata), 32'h1111);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Push while full with a simultaneous pop is accepted.
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    tready = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    check("pp_count", 32'(count), 4);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("drain_empty", 32'(empty), 1);
    exp4[0] = 16'h1111; exp4[1] = 16'h2222; exp4[2] = 16'h3333;
    exp4[3] = 16'h4444; exp4[4] = 16'h6666;
    check("drain_n", dut_sink.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (dut_sink.size() > i) check("drain_data", 32'(dut_sink[i][DW-1:0]), 32'(exp4[i]));
    end
    dut_sink.delete();

    // Same-cycle byte write and push.
    tready = 1'b0;
    drive(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0);
    check("same_tdata", 32'(tdata), 32'hABCD);
    check("same_tlast", 32'(tlast), 1);
    tready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("same_empty", 32'(empty), 1);
    dut_sink.delete();

    // Asynchronous reset with three words queued.
    tready = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("pre_rst_tvalid", 32'(tvalid), 1);
    check("pre_rst_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(tvalid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tready = 1'b1;
    repeat (4) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("post_rst_sink", dut_sink.size(), 0);
    check("post_rst_tvalid", 32'(tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
